// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO (fifo_param, fifo_ptr).
// FIFO_REG_OUT_EN (in fifo_param) selects registered read data over show-ahead.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic udf;
  } fifo_flags_t;

  function automatic int unsigned ocp_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer register (0..DEPTH-1) with increment and synchronous clear.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= PW'(ptr_inc(32'(ptr), DEPTH));
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised FIFO with occupancy, threshold flags, sticky error flags and flush.
// Define FIFO_REG_OUT_EN for registered read data; default is show-ahead.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  localparam int unsigned OW = ocp_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_out,
  output logic          is_full,
  output logic          is_empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [OW-1:0] ocp,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam logic [OW-1:0] OCP_FULL = OW'(DEPTH);
  localparam logic [OW-1:0] AF_L     = OW'(AF_LEVEL);
  localparam logic [OW-1:0] AE_L     = OW'(AE_LEVEL);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign is_full      = (ocp == OCP_FULL);
  assign is_empty     = (ocp == '0);
  assign almost_full  = (ocp >= AF_L);
  assign almost_empty = (ocp <= AE_L);

  always_comb begin
    pop_ok  = pop & ~is_empty;
    push_ok = push & (~is_full | pop_ok);
  end

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (push_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (pop_ok),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= dat_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocp <= '0;
    end else if (clr) begin
      ocp <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   ocp <= ocp + OW'(1);
        2'b01:   ocp <= ocp - OW'(1);
        default: ocp <= ocp;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_ok) overflow  <= 1'b1;
      if (pop && !pop_ok)   underflow <= 1'b1;
    end
  end

`ifdef FIFO_REG_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dat_out <= '0;
    else if (clr)    dat_out <= '0;
    else if (pop_ok) dat_out <= mem[rd_ptr];
  end
`else
  assign dat_out = mem[rd_ptr];
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Randomised and directed bench for fifo_param (DEPTH=5) against a queue model.
// Follows FIFO_REG_OUT_EN to pick the expected read latency.
module tb_fifo_param;
  import fifo_pkg::*;

  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic        clk = 1'b0;
  logic        rst, clr, push, pop;
  logic [31:0] dat_in;
  logic [31:0] dat_out;
  logic        is_full, is_empty, almost_full, almost_empty;
  logic [2:0]  ocp;
  logic        overflow, underflow;

  int tests = 0;
  int fails = 0;

  logic [31:0] q[$];
  bit          m_ovf, m_udf;
  bit          m_popv;
  logic [31:0] m_popd;
`ifdef FIFO_REG_OUT_EN
  logic [31:0] m_dout;
`else
  logic [31:0] pre_dout;
`endif

  fifo_param #(.DW(32), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .push         (push),
    .pop          (pop),
    .dat_in       (dat_in),
    .dat_out      (dat_out),
    .is_full      (is_full),
    .is_empty     (is_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ocp          (ocp),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  function automatic fifo_flags_t exp_flags();
    fifo_flags_t f;
    f.full   = (q.size() == DEPTH);
    f.empty  = (q.size() == 0);
    f.afull  = (q.size() >= AF);
    f.aempty = (q.size() <= AE);
    f.ovf    = m_ovf;
    f.udf    = m_udf;
    return f;
  endfunction

  function automatic fifo_flags_t obs_flags();
    return '{full: is_full, empty: is_empty, afull: almost_full,
             aempty: almost_empty, ovf: overflow, udf: underflow};
  endfunction

  // Word delivered by the most recent pop, at the latency of the build.
  function automatic logic [31:0] pop_obs();
`ifdef FIFO_REG_OUT_EN
    return dat_out;
`else
    return pre_dout;
`endif
  endfunction

  function automatic void model_clear();
    q.delete();
    m_ovf  = 0;
    m_udf  = 0;
    m_popv = 0;
`ifdef FIFO_REG_OUT_EN
    m_dout = '0;
`endif
  endfunction

  task automatic drive(input bit p, input bit o, input logic [31:0] d, input bit c);
    bit pok, puk;
    @(negedge clk);
    push = p; pop = o; dat_in = d; clr = c;
    #2;
`ifndef FIFO_REG_OUT_EN
    pre_dout = dat_out;
`endif
    @(posedge clk);
    m_popv = 0;
    if (c) begin
      model_clear();
    end else begin
      pok = o && (q.size() > 0);
      puk = p && ((q.size() < DEPTH) || pok);
      if (o && !pok) m_udf = 1;
      if (p && !puk) m_ovf = 1;
      if (pok) begin
        m_popd = q.pop_front();
        m_popv = 1;
`ifdef FIFO_REG_OUT_EN
        m_dout = m_popd;
`endif
      end
      if (puk) q.push_back(d);
    end
    #1;
    push = 0; pop = 0; clr = 0;
  endtask

  task automatic test_reset();
    rst = 0; clr = 0; push = 0; pop = 0; dat_in = '0;
    #1 rst = 1;
    model_clear();
    #12;
    tests++;
    if (ocp !== 3'd0) begin fails++; $display("FAIL reset_ocp: got %0d expected 0", ocp); end
    tests++;
    if (obs_flags() !== fifo_flags_t'(6'b010100)) begin
      fails++; $display("FAIL reset_flags: got %b expected 010100", obs_flags());
    end
`ifdef FIFO_REG_OUT_EN
    tests++;
    if (dat_out !== 32'h0) begin fails++; $display("FAIL reset_dout: got %h expected 0", dat_out); end
`endif
    @(negedge clk) rst = 0;
    repeat (2) drive(0, 0, '0, 0);
    tests++;
    if (obs_flags() !== fifo_flags_t'(6'b010100) || ocp !== 3'd0) begin
      fails++; $display("FAIL idle_state: got %b/%0d expected 010100/0", obs_flags(), ocp);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 32'hA0 + i, 0);
      tests++;
      if (almost_full !== (i >= 3) || is_full !== (i == 4) || ocp !== 3'(i + 1)) begin
        fails++;
        $display("FAIL fill_flags: got af=%b f=%b ocp=%0d expected af=%b f=%b ocp=%0d",
                 almost_full, is_full, ocp, i >= 3, i == 4, i + 1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, '0, 0);
      tests++;
      if (pop_obs() !== 32'hA0 + i) begin
        fails++; $display("FAIL drain_data: got %h expected %h", pop_obs(), 32'hA0 + i);
      end
    end
    tests++;
    if (is_empty !== 1'b1 || almost_empty !== 1'b1 || ocp !== 3'd0) begin
      fails++; $display("FAIL drain_empty: got e=%b ae=%b ocp=%0d expected 1 1 0", is_empty, almost_empty, ocp);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] nxt_in, nxt_out;
    nxt_in = 32'h100; nxt_out = 32'h100;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) begin
        drive(1, 0, nxt_in, 0);
        nxt_in++;
        tests++;
        if (ocp > 3'd3) begin fails++; $display("FAIL wrap_ocp: got %0d expected <=3", ocp); end
      end
      for (int k = 0; k < 3; k++) begin
        drive(0, 1, '0, 0);
        tests++;
        if (pop_obs() !== nxt_out) begin
          fails++; $display("FAIL wrap_data: got %h expected %h", pop_obs(), nxt_out);
        end
        nxt_out++;
      end
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 5; i++) drive(1, 0, 32'hC0 + i, 0);
    drive(1, 1, 32'hBB, 0);
    tests++;
    if (pop_obs() !== 32'hC0) begin fails++; $display("FAIL full_pp_head: got %h expected c0", pop_obs()); end
    tests++;
    if (ocp !== 3'd5 || is_full !== 1'b1 || overflow !== 1'b0) begin
      fails++; $display("FAIL full_pp_state: got ocp=%0d f=%b ovf=%b expected 5 1 0", ocp, is_full, overflow);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, '0, 0);
      tests++;
      if (pop_obs() !== ((i == 4) ? 32'hBB : 32'hC1 + i)) begin
        fails++; $display("FAIL full_pp_order: got %h expected %h", pop_obs(), (i == 4) ? 32'hBB : 32'hC1 + i);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) drive(1, 0, 32'hE0 + i, 0);
    drive(1, 0, 32'hCC, 0);
    tests++;
    if (overflow !== 1'b1 || ocp !== 3'd5) begin
      fails++; $display("FAIL ovf_set: got ovf=%b ocp=%0d expected 1 5", overflow, ocp);
    end
    drive(0, 0, '0, 0);
    tests++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, '0, 0);
      tests++;
      if (pop_obs() !== 32'hE0 + i) begin
        fails++; $display("FAIL ovf_contents: got %h expected %h", pop_obs(), 32'hE0 + i);
      end
    end
    tests++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_hold: got %b expected 1", overflow); end
    drive(1, 0, 32'h55, 1);
    tests++;
    if (overflow !== 1'b0 || ocp !== 3'd0) begin
      fails++; $display("FAIL ovf_clr: got ovf=%b ocp=%0d expected 0 0", overflow, ocp);
    end
  endtask

  task automatic test_empty_pushpop();
    drive(1, 1, 32'hDD, 0);
    tests++;
    if (underflow !== 1'b1 || ocp !== 3'd1) begin
      fails++; $display("FAIL empty_pp: got udf=%b ocp=%0d expected 1 1", underflow, ocp);
    end
    drive(0, 1, '0, 0);
    tests++;
    if (pop_obs() !== 32'hDD || ocp !== 3'd0) begin
      fails++; $display("FAIL empty_pp_data: got %h/%0d expected dd/0", pop_obs(), ocp);
    end
    drive(1, 0, 32'hEE, 1);
    tests++;
    if (ocp !== 3'd0 || is_empty !== 1'b1 || underflow !== 1'b0) begin
      fails++; $display("FAIL clr_push: got ocp=%0d e=%b udf=%b expected 0 1 0", ocp, is_empty, underflow);
    end
`ifdef FIFO_REG_OUT_EN
    tests++;
    if (dat_out !== 32'h0) begin fails++; $display("FAIL clr_dout: got %h expected 0", dat_out); end
`endif
  endtask

  task automatic test_random();
    bit p, o, c;
    for (int n = 0; n < 400; n++) begin
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 2);
      drive(p, o, $urandom, c);
      tests++;
      if (obs_flags() !== exp_flags() || ocp !== 3'(q.size())) begin
        fails++; $display("FAIL rand_state: got %b/%0d expected %b/%0d", obs_flags(), ocp, exp_flags(), q.size());
      end
      if (m_popv) begin
        tests++;
        if (pop_obs() !== m_popd) begin
          fails++; $display("FAIL rand_data: got %h expected %h", pop_obs(), m_popd);
        end
      end
`ifdef FIFO_REG_OUT_EN
      tests++;
      if (dat_out !== m_dout) begin fails++; $display("FAIL rand_hold: got %h expected %h", dat_out, m_dout); end
`endif
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, '0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 32'h70 + i, 0);
    @(negedge clk);
    #1 rst = 1;
    #1;
    tests++;
    if (ocp !== 3'd0 || is_empty !== 1'b1) begin
      fails++; $display("FAIL async_rst: got ocp=%0d e=%b expected 0 1", ocp, is_empty);
    end
    model_clear();
    @(negedge clk) rst = 0;
    drive(0, 0, '0, 0);
    tests++;
    if (obs_flags() !== exp_flags() || ocp !== 3'd0) begin
      fails++; $display("FAIL post_rst: got %b expected %b", obs_flags(), exp_flags());
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pushpop();
    test_overflow();
    test_empty_pushpop();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised successor to the single-width FIFO used around the array edges.
- Generalises data width and depth; depth need not be a power of two.
- Adds almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Sits between the host-side feeders and the systolic-array row/column inputs. Also serves as a general elastic buffer elsewhere in the design.

Parameters:
- DW, 32: data width in bits (>=1).
- DEPTH, 4: number of entries (>=2, any integer).
- AF_LEVEL, DEPTH-1: almost_full asserts when ocp >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1: almost_empty asserts when ocp <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush.
- push  in  1  write request.
- pop  in  1  read request.
- dat_in  in  DW  write data.
- dat_out  out  DW  read data.
- is_full  out  1  ocp == DEPTH.
- is_empty  out  1  ocp == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- ocp  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was dropped.

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are clk and rst.
- Reset values: ocp=0, wr_ptr=rd_ptr=0, is_empty=1, almost_empty=1, is_full=0, almost_full=0, overflow=0, underflow=0, dat_out=0. Storage array is not reset.
- Reset asserted mid-operation discards all contents immediately.
- Pointers run 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. Power-of-two arithmetic must not be relied upon.
- Flags are derived combinationally from the registered ocp, so they update in the same cycle as ocp.
- push_ok = push & (!is_full | pop_ok).
  - Accepted push writes dat_in at wr_ptr and advances wr_ptr.
  - A push with is_full and no pop_ok is dropped, sets overflow, and leaves state unchanged.
- pop_ok = pop & !is_empty.
  - Accepted pop advances rd_ptr.
  - A pop with is_empty is dropped and sets underflow. A push in the same cycle is still accepted.
- Simultaneous push_ok and pop_ok: both take effect, ocp unchanged. This holds when full (slot recycled) and at any middle level.
- ocp next value:
  - ocp+1 on push_ok only.
  - ocp-1 on pop_ok only.
  - Otherwise unchanged.
- clr has priority over push and pop in the same cycle. It zeroes pointers and ocp and clears overflow and underflow; the push/pop in that cycle is ignored. If FIFO_REG_OUT_EN is defined, clr also zeroes dat_out.
- overflow and underflow stay high until clr or rst.
- Read latency: see Optional Feature.

Optional Feature:
- Macro: FIFO_REG_OUT_EN.
- Undefined (show-ahead):
  - dat_out = mem[rd_ptr] combinationally.
  - Valid whenever !is_empty; value is don't-care while empty.
  - A pop consumes the word visible in that cycle.
- Defined (registered read):
  - On pop_ok, dat_out registers mem[rd_ptr] at the clock edge, so the popped word appears one cycle after pop.
  - dat_out holds its value until the next pop_ok.
  - Improves timing into array inputs.

Decomposition:
- Package fifo_pkg:
  - Function ptr_inc(ptr, depth) implementing the wrap.
  - Localparam helper for ocp width: $clog2(DEPTH+1).
  - Typedef fifo_flags_t (packed struct: full, empty, afull, aempty, ovf, udf) for bench monitors.
- One natural sub-module: fifo_ptr.
  - Wrap-around pointer register with inc and clr inputs.
  - Instantiated twice, for read and write.

Test Plan (DW=32, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1 unless noted):
- Reset then idle:
  - ocp=0, is_empty=1, almost_empty=1, flags 0.
  - Assert rst mid-stream at ocp=3: ocp=0 and is_empty=1 without waiting for a clock edge.
- Push 0xA0..0xA4, then pop 5:
  - almost_full rises at ocp=4; is_full at ocp=5.
  - Pops return A0..A4 in order: same cycle in show-ahead, +1 cycle with FIFO_REG_OUT_EN.
  - is_empty=1 at end.
- Wrap-around: repeatedly push 3 / pop 3 for 10 rounds with incrementing data:
  - Data intact across the pointer wrap at 4->0.
  - ocp never exceeds 3.
- Full with push+pop in the same cycle, push 0xBB:
  - Head word popped; ocp stays 5; overflow=0.
  - 0xBB later emerges last.
- Push 0xCC while full (no pop):
  - Dropped; overflow=1 and stays 1.
  - Contents unchanged.
  - Next clr: ocp=0, overflow=0.
- Empty with push+pop in the same cycle, push 0xDD:
  - Pop dropped; underflow=1.
  - ocp=1; next pop returns 0xDD.
  - clr asserted together with push: ocp=0, push ignored.
